// File: rtl/rv32_pkg.sv
// Shared RV32 constants for the front end: the NOP encoding, the default datapath widths
// and the default reset PC.
package rv32_pkg;

    localparam int          DEFAULT_PC_WIDTH   = 32;
    localparam int          DEFAULT_INST_WIDTH = 32;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP                = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and squash controls.
// Priority is rst > squash > load > hold. A squash keeps the PC fields and inserts a bubble.
module if_id_reg
    import rv32_pkg::*;
#(
    parameter int PC_width   = DEFAULT_PC_WIDTH,
    parameter int inst_width = DEFAULT_INST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  squash,
    input  logic [PC_width-1:0]   pc_in,
    input  logic [PC_width-1:0]   pc_plus4_in,
    input  logic [inst_width-1:0] inst_in,
    input  logic                  misalign_in,
    output logic [PC_width-1:0]   pc_out,
    output logic [PC_width-1:0]   pc_plus4_out,
    output logic [inst_width-1:0] inst_out,
    output logic                  valid_out,
    output logic                  misalign_out
);

    localparam logic [inst_width-1:0] NOP_W = inst_width'(NOP);

    logic [PC_width-1:0]   pc_reg;
    logic [PC_width-1:0]   pc_plus4_reg;
    logic [inst_width-1:0] inst_reg;
    logic                  valid_reg;
    logic                  misalign_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= '0;
            pc_plus4_reg <= '0;
            inst_reg     <= NOP_W;
            valid_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else if (squash) begin
            inst_reg     <= NOP_W;
            valid_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else if (load) begin
            pc_reg       <= pc_in;
            pc_plus4_reg <= pc_plus4_in;
            inst_reg     <= inst_in;
            valid_reg    <= 1'b1;
            misalign_reg <= misalign_in;
        end
    end

    assign pc_out       = pc_reg;
    assign pc_plus4_out = pc_plus4_reg;
    assign inst_out     = inst_reg;
    assign valid_out    = valid_reg;
    assign misalign_out = misalign_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC register and feeds the IF/ID register.
// Optional build macro FETCH_MISALIGN_TRAP_EN keeps misaligned targets and flags their fetches.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter int                  PC_width   = DEFAULT_PC_WIDTH,
    parameter int                  inst_width = DEFAULT_INST_WIDTH,
    parameter logic [PC_width-1:0] RESET_PC   = PC_width'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_width-1:0]   redirect_target,
    output logic [PC_width-1:0]   PC,
    input  logic [inst_width-1:0] instruction,
    output logic [PC_width-1:0]   if_id_pc,
    output logic [PC_width-1:0]   if_id_pc_plus4,
    output logic [inst_width-1:0] if_id_inst,
    output logic                  if_id_valid,
    output logic                  if_id_misalign
);

    logic [PC_width-1:0]   pc_reg;
    logic [PC_width-1:0]   pc_next;
    logic [PC_width-1:0]   pc_plus4;
    logic [PC_width-1:0]   target;
    logic [inst_width-1:0] inst_capture;
    logic                  misalign;
    logic                  load;
    logic                  squash;

    // The +4 wraps naturally at the top of the address space.
    assign pc_plus4 = pc_reg + PC_width'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target       = redirect_target;
    assign misalign     = (pc_reg[1:0] != 2'b00);
    assign inst_capture = misalign ? inst_width'(NOP) : instruction;
`else
    assign target       = redirect_target & ~PC_width'(3);
    assign misalign     = 1'b0;
    assign inst_capture = instruction;
`endif

    // Redirect beats stall; otherwise advance unless decode is holding us.
    always_comb begin
        pc_next = pc_reg;
        load    = 1'b0;
        squash  = 1'b0;
        if (redirect) begin
            pc_next = target;
            squash  = 1'b1;
        end else if (!stall) begin
            pc_next = pc_plus4;
            load    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign PC = pc_reg;

    if_id_reg #(
        .PC_width   (PC_width),
        .inst_width (inst_width)
    ) u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .squash       (squash),
        .pc_in        (pc_reg),
        .pc_plus4_in  (pc_plus4),
        .inst_in      (inst_capture),
        .misalign_in  (misalign),
        .pc_out       (if_id_pc),
        .pc_plus4_out (if_id_pc_plus4),
        .inst_out     (if_id_inst),
        .valid_out    (if_id_valid),
        .misalign_out (if_id_misalign)
    );

endmodule
